weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- Parametrised weight-staging block for the systolic MMU.
- Buffers whole SIZE x SIZE weight tiles in an internal tile FIFO.
- On request, shifts the head tile row-by-row into the array's shadow weight registers, optionally transposed.
- Then issues a single swap pulse once the array is not busy.
- Sits between the host weight-push interface and the mmu_array load_weight/swap_weights/weight_in pins.

Parameters:
SIZE, 4, array dimension (tile is SIZE x SIZE), SIZE >= 2
DATA_W, 8, weight element width in bits
DEPTH, 4, tile FIFO capacity in tiles, DEPTH >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tile_in  in  DATA_W x [SIZE][SIZE]  tile to push, tile_in[r][c] = row r, column c
tile_push  in  1  push request
tile_push_rdy  out  1  FIFO can accept a tile
tile_count  out  $clog2(DEPTH+1)  tiles currently stored
ld_start  in  1  request load of head tile
ld_transpose  in  1  transpose mode, sampled only when ld_start is accepted
ld_rdy  out  1  load can be accepted
ld_done  out  1  one-cycle pulse, coincident with arr_swap_weights
arr_busy  in  1  array mid-multiply; swap must be deferred
arr_weight_out  out  DATA_W x [SIZE]  row presented to array weight_in
arr_ld_weight  out  1  shift strobe to array
arr_swap_weights  out  1  one-cycle swap pulse to array

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous, active-low.
- Reset values:
  - FIFO empty; tile_count=0; tile_push_rdy=1.
  - FSM=IDLE; ld_rdy=0.
  - arr_weight_out all 0; arr_ld_weight=0; arr_swap_weights=0; ld_done=0.
- Reset mid-load aborts immediately. Tile being shifted is discarded and no swap is issued.
- Push:
  - tile_push_rdy = (tile_count < DEPTH).
  - A push is accepted on an edge where tile_push && tile_push_rdy. Push while full is ignored with no state change.
  - No bypass: a tile pushed into an empty FIFO is poppable from the next cycle.
- Pop:
  - Internal only, on the final SHIFT cycle.
  - Push and pop on the same edge leave tile_count unchanged.
  - At full, a pop does not make tile_push_rdy high in the same cycle.
- Read/write pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
- ld_rdy = (state == IDLE) && (tile_count > 0).
- FSM states: IDLE, SHIFT, WAIT_SWAP.
  - IDLE -> SHIFT on ld_start && ld_rdy. On that edge: latch ld_transpose, row counter r=0. ld_start while not ld_rdy is ignored, not queued.
  - SHIFT: lasts exactly SIZE cycles, r = 0..SIZE-1.
    - Each cycle: arr_ld_weight=1; arr_weight_out[c] = head[SIZE-1-r][c], or head[c][SIZE-1-r] when transpose is latched.
    - The last row enters first, so row 0 ends in array row 0.
    - Outputs are registered and change only at edges.
    - On the cycle r=SIZE-1, pop the head. Go to WAIT_SWAP.
  - WAIT_SWAP:
    - arr_ld_weight=0 and arr_weight_out returns to 0.
    - While arr_busy=1, hold with no pulses.
    - When arr_busy=0, assert arr_swap_weights=1 and ld_done=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge T.
  - arr_ld_weight is high in cycles T+1 .. T+SIZE.
  - tile_count decrements at edge T+SIZE.
  - Earliest swap/ld_done is cycle T+SIZE+1.
  - ld_rdy is high again no earlier than cycle T+SIZE+2.
- ld_start and ld_transpose are don't-care outside IDLE.
- Pushes continue normally during SHIFT and WAIT_SWAP.
- arr_busy is ignored outside WAIT_SWAP.
- Data path is pure data movement with no arithmetic. Element width is DATA_W throughout.

Test Plan:
- Reset then idle check: rst_n low at an arbitrary mid-cycle point. Required response, asynchronously: outputs 0, tile_push_rdy=1, ld_rdy=0, tile_count=0.
- Fill/overflow, DEPTH=4: push 5 tiles on consecutive cycles.
  - Required: tile_count=4, tile_push_rdy=0 after the 4th.
  - 5th push is ignored; loads then return tiles 1..4 in order.
- Normal load, SIZE=4: tile[r][c]=16r+c, ld_start with transpose=0, arr_busy=0.
  - Required: 4 arr_ld_weight cycles presenting rows {48..51}, {32..35}, {16..19}, {0..3}.
  - Then one swap and ld_done pulse on the next cycle; tile_count 1 -> 0.
- Transpose load: same tile, ld_transpose=1.
  - Required rows: {3,19,35,51}, {2,18,34,50}, {1,17,33,49}, {0,16,32,48}.
- Busy stall: arr_busy=1 for 10 cycles after SHIFT.
  - Required: no swap while busy; a single swap pulse the cycle arr_busy falls.
  - ld_start during the stall is ignored.
- Boundary mix:
  - Push on the same edge as the final-SHIFT pop at count=2: count stays 2.
  - ld_start on empty FIFO: no response.
  - rst_n asserted mid-SHIFT at r=2: no swap, count=0, FSM IDLE.

Source files
------------

// File: rtl/weight_loader.sv
// Weight-staging block for the systolic MMU: buffers SIZE x SIZE tiles in a FIFO and
// shifts the head tile row-by-row (optionally transposed) into the array, then swaps.
module weight_loader #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]  tile_in,
  input  logic                                   tile_push,
  output logic                                   tile_push_rdy,
  output logic [$clog2(DEPTH+1)-1:0]             tile_count,
  input  logic                                   ld_start,
  input  logic                                   ld_transpose,
  output logic                                   ld_rdy,
  output logic                                   ld_done,
  input  logic                                   arr_busy,
  output logic [SIZE-1:0][DATA_W-1:0]            arr_weight_out,
  output logic                                   arr_ld_weight,
  output logic                                   arr_swap_weights
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(SIZE);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_t;
  typedef logic [SIZE-1:0][DATA_W-1:0]           row_t;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SWAP} state_t;

  // Shift order is last row first, so row 0 lands in array row 0.
  function automatic row_t sel_row(tile_t t, logic [RW-1:0] r, logic tr);
    row_t row;
    int   ri;
    ri = SIZE - 1 - int'(r);
    for (int c = 0; c < SIZE; c++) row[c] = tr ? t[c][ri] : t[ri][c];
    return row;
  endfunction

  function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  tile_t           mem_q [DEPTH];
  tile_t           mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            trans_q, trans_d;
  row_t            wout_q, wout_d;
  logic            ldw_q, ldw_d;
  logic            push_acc, ld_acc, last_row;

  assign tile_push_rdy  = (count_q < CW'(DEPTH));
  assign tile_count     = count_q;
  assign push_acc       = tile_push && tile_push_rdy;
  assign ld_acc         = ld_start && ld_rdy;
  assign last_row       = (state_q == SHIFT) && (row_q == RW'(SIZE-1));
  assign arr_weight_out = wout_q;
  assign arr_ld_weight  = ldw_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = tile_in;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (last_row) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_acc, last_row})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (ld_acc) state_d = SHIFT;
      SHIFT:     if (last_row) state_d = WAIT_SWAP;
      WAIT_SWAP: if (!arr_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered shift outputs: the row for cycle r is prepared on the edge before it.
  always_comb begin
    row_d   = row_q;
    trans_d = trans_q;
    wout_d  = '0;
    ldw_d   = 1'b0;
    if (state_q == IDLE && ld_acc) begin
      row_d   = '0;
      trans_d = ld_transpose;
      wout_d  = sel_row(mem_q[rd_ptr_q], '0, ld_transpose);
      ldw_d   = 1'b1;
    end else if (state_q == SHIFT && !last_row) begin
      row_d  = row_q + 1'b1;
      wout_d = sel_row(mem_q[rd_ptr_q], row_q + 1'b1, trans_q);
      ldw_d  = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    ld_rdy           = (state_q == IDLE) && (count_q != '0);
    arr_swap_weights = (state_q == WAIT_SWAP) && !arr_busy;
    ld_done          = arr_swap_weights;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      row_q    <= '0;
      trans_q  <= 1'b0;
      wout_q   <= '0;
      ldw_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      row_q    <= row_d;
      trans_q  <= trans_d;
      wout_q   <= wout_d;
      ldw_q    <= ldw_d;
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// Directed + randomized bench for weight_loader against a tile-queue reference model.
module tb_weight_loader;
  localparam int SIZE = 4, DATA_W = 8, DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_t;
  typedef logic [SIZE-1:0][DATA_W-1:0]           row_t;

  logic clk = 0, rst_n = 0;
  tile_t tile_in = '0;
  logic tile_push = 0, ld_start = 0, ld_transpose = 0, arr_busy = 0;
  logic tile_push_rdy, ld_rdy, ld_done, arr_ld_weight, arr_swap_weights;
  logic [CW-1:0] tile_count;
  row_t arr_weight_out;

  weight_loader #(.SIZE(SIZE), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tile_in(tile_in), .tile_push(tile_push),
    .tile_push_rdy(tile_push_rdy), .tile_count(tile_count), .ld_start(ld_start),
    .ld_transpose(ld_transpose), .ld_rdy(ld_rdy), .ld_done(ld_done), .arr_busy(arr_busy),
    .arr_weight_out(arr_weight_out), .arr_ld_weight(arr_ld_weight),
    .arr_swap_weights(arr_swap_weights)
  );

  always #5 clk = ~clk;

  tile_t q[$];
  int n_chk = 0, n_pass = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row seen at the k-th shift cycle: tile row SIZE-1-k, or column SIZE-1-k when transposed.
  function automatic row_t exp_row(tile_t t, int k, bit tr);
    row_t row;
    for (int c = 0; c < SIZE; c++) row[c] = tr ? t[c][SIZE-1-k] : t[SIZE-1-k][c];
    return row;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) t[r][c] = DATA_W'($urandom);
    return t;
  endfunction

  task automatic push(tile_t t);
    bit acc;
    acc = (q.size() < DEPTH);
    tile_in = t;
    tile_push = 1;
    @(negedge clk);
    check("push_rdy", 64'(tile_push_rdy), 64'(acc));
    tick();
    tile_push = 0;
    if (acc) q.push_back(t);
    check("push_count", 64'(tile_count), 64'(q.size()));
  endtask

  task automatic idle_check(string tag);
    check({tag, "_ldw"}, 64'(arr_ld_weight), 64'd0);
    check({tag, "_wout"}, 64'(arr_weight_out), 64'd0);
    check({tag, "_swap"}, 64'({arr_swap_weights, ld_done}), 64'd0);
    check({tag, "_count"}, 64'(tile_count), 64'd0);
    check({tag, "_rdy"}, 64'({tile_push_rdy, ld_rdy}), 64'b10);
  endtask

  task automatic load(bit tr, int busy, bit push_last);
    tile_t head, extra;
    head = q[0];
    extra = rand_tile();
    ld_start = 1;
    ld_transpose = tr;
    arr_busy = (busy > 0);
    @(negedge clk);
    check("ld_rdy_before", 64'(ld_rdy), 64'd1);
    tick();
    ld_start = 0;
    ld_transpose = $urandom_range(0, 1);
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      check("shift_ldw", 64'(arr_ld_weight), 64'd1);
      check("shift_row", 64'(arr_weight_out), 64'(exp_row(head, k, tr)));
      check("shift_swap", 64'(arr_swap_weights), 64'd0);
      if (k == SIZE-1 && push_last) begin
        tile_in = extra;
        tile_push = 1;
      end
      tick();
    end
    tile_push = 0;
    void'(q.pop_front());
    if (push_last) q.push_back(extra);
    check("pop_count", 64'(tile_count), 64'(q.size()));
    for (int i = 0; i < busy; i++) begin
      ld_start = 1;
      @(negedge clk);
      check("stall_swap", 64'({arr_swap_weights, ld_done}), 64'd0);
      check("stall_ldw", 64'({arr_ld_weight, ld_rdy}), 64'd0);
      check("stall_wout", 64'(arr_weight_out), 64'd0);
      tick();
    end
    arr_busy = 0;
    ld_start = 0;
    #1;
    check("swap_pulse", 64'({arr_swap_weights, ld_done}), 64'b11);
    check("swap_wout", 64'(arr_weight_out), 64'd0);
    tick();
    check("after_swap", 64'({arr_swap_weights, ld_done, arr_ld_weight}), 64'd0);
    check("after_rdy", 64'(ld_rdy), 64'(q.size() > 0));
    check("after_count", 64'(tile_count), 64'(q.size()));
  endtask

  initial begin
    tile_t seq_t;
    #3;
    idle_check("reset0");
    #20 rst_n = 1;
    tick();
    idle_check("idle");

    // Asynchronous reset mid-cycle with tiles stored
    push(rand_tile());
    push(rand_tile());
    #2 rst_n = 0;
    #1;
    q.delete();
    idle_check("async_rst");
    #2 rst_n = 1;
    tick();

    // Fill and overflow: 5th push ignored, drain returns tiles in order
    for (int i = 0; i < 5; i++) push(rand_tile());
    check("full_rdy", 64'(tile_push_rdy), 64'd0);
    for (int i = 0; i < DEPTH; i++) load($urandom_range(0, 1), 0, 0);

    // Normal and transposed load of tile[r][c] = 16r+c
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) seq_t[r][c] = DATA_W'(16*r + c);
    push(seq_t);
    load(0, 0, 0);
    push(seq_t);
    load(1, 0, 0);

    // Busy stall, ld_start during stall ignored
    push(rand_tile());
    load(0, 10, 0);

    // Push coincident with the final-shift pop at count=2
    push(rand_tile());
    push(rand_tile());
    load(1, 0, 1);
    check("push_pop_count", 64'(tile_count), 64'd2);
    load(0, 1, 0);
    load(1, 0, 0);

    // ld_start on empty FIFO
    ld_start = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_ldw", 64'({arr_ld_weight, ld_rdy, arr_swap_weights}), 64'd0);
      tick();
    end
    ld_start = 0;

    // Reset during SHIFT at r=2
    push(rand_tile());
    ld_start = 1;
    tick();
    ld_start = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    q.delete();
    idle_check("midshift_rst");
    #1 rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_swap_after_rst", 64'({arr_swap_weights, ld_done, arr_ld_weight}), 64'd0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 12; i++) begin
      if (q.size() == 0 || ($urandom_range(0, 2) == 0)) push(rand_tile());
      else load($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
